// File: rtl/capture_ram_if.sv
// capture_ram_if: single-port sample RAM bus between the
// capture controller (master) and the 2^AW x DW RAM (slave).
interface capture_ram_if #(
  parameter int AW = 9,
  parameter int DW = 8
) ();
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: decimating circular-buffer acquisition with
// level/edge trigger and oldest-first readout of the RAM.
module capture_ctrl #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          arm,
  input  logic          smpl_vld,
  input  logic [DW-1:0] smpl,
  input  logic [DW-1:0] trig_lvl,
  input  logic          trig_edge,
  input  logic [AW-1:0] trig_pos,
  input  logic [3:0]    decim,
  input  logic          rd_req,
  capture_ram_if.master ram,
  output logic [DW-1:0] rd_data,
  output logic          rd_vld,
  output logic          triggered,
  output logic          capture_done,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE,
    S_READ
  } state_e;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [3:0]    decim_q;
  logic [3:0]    decim_cnt_q;
  logic [AW-1:0] tpos_q;
  logic [AW-1:0] pre_cnt_q;
  logic [AW-1:0] post_cnt_q;
  logic [DW-1:0] prev_q;
  logic          prev_vld_q;
  logic          trig_q;
  logic          done_q;
  logic [AW-1:0] rd_base_q;
  logic [AW-1:0] rd_cnt_q;
  logic          rd_vld_q;

  logic          cap;
  logic          acc;
  logic          wr;
  logic          rd;
  logic          rise;
  logic          fall;
  logic          hit;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] pre_len;
  logic [AW-1:0] rd_addr;

  assign cap = (state_q == S_PRE) ||
               (state_q == S_WAIT) ||
               (state_q == S_POST);
  assign acc = smpl_vld && (decim_cnt_q == decim_q);
  assign wr  = !rst && !arm && cap && acc;
  assign rd  = !rst && (state_q == S_READ);

  assign wr_ptr_d = wr_ptr_q + 1'b1;
  // 2^AW - tpos, taken modulo 2^AW; tpos is never 0
  assign pre_len  = AW'(0) - tpos_q;
  assign rd_addr  = rd_base_q + rd_cnt_q;

  assign rise = (prev_q < trig_lvl) && (smpl >= trig_lvl);
  assign fall = (prev_q > trig_lvl) && (smpl <= trig_lvl);
  assign hit  = (state_q == S_WAIT) && acc && prev_vld_q &&
                (trig_edge ? rise : fall);

  assign ram.ram_en    = wr | rd;
  assign ram.ram_we    = wr;
  assign ram.ram_addr  = rd ? rd_addr : (wr ? wr_ptr_q : '0);
  assign ram.ram_wdata = wr ? smpl : '0;

  assign rd_vld       = rd_vld_q;
  assign rd_data      = rd_vld_q ? ram.ram_rdata : '0;
  assign triggered    = trig_q;
  assign capture_done = done_q;
  assign busy         = cap || (state_q == S_READ);

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      decim_q     <= '0;
      decim_cnt_q <= '0;
      tpos_q      <= AW'(1);
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_base_q   <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
    end else if (arm) begin
      state_q     <= S_PRE;
      tpos_q      <= (trig_pos == '0) ? AW'(1) : trig_pos;
      decim_q     <= decim;
      wr_ptr_q    <= '0;
      decim_cnt_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      prev_vld_q  <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      rd_vld_q <= rd;
      if (cap && smpl_vld) begin
        decim_cnt_q <= acc ? '0 : decim_cnt_q + 1'b1;
      end
      if (wr) begin
        wr_ptr_q   <= wr_ptr_d;
        prev_q     <= smpl;
        prev_vld_q <= 1'b1;
      end
      unique case (state_q)
        S_PRE: begin
          if (acc) begin
            pre_cnt_q <= pre_cnt_q + 1'b1;
            if (pre_cnt_q + 1'b1 == pre_len) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (hit) begin
            trig_q     <= 1'b1;
            post_cnt_q <= AW'(1);
            if (tpos_q == AW'(1)) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              rd_base_q <= wr_ptr_d;
            end else begin
              state_q <= S_POST;
            end
          end
        end
        S_POST: begin
          if (acc) begin
            post_cnt_q <= post_cnt_q + 1'b1;
            // write pointer now sits on the oldest sample
            if (post_cnt_q + 1'b1 == tpos_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              rd_base_q <= wr_ptr_d;
            end
          end
        end
        S_DONE: begin
          if (rd_req) begin
            state_q  <= S_READ;
            rd_cnt_q <= '0;
          end
        end
        S_READ: begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
          if (rd_cnt_q == '1) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Acquisition controller sitting directly upstream of the 512x8 sample RAM. It decimates an incoming 8-bit sample stream, writes samples circularly into the RAM, detects a level/edge trigger, and completes a capture with a programmable number of post-trigger samples. On request it streams the 512 captured samples back out, oldest first, by driving the RAM read port.

Parameters:
AW, 9, RAM address width; buffer depth = 2^AW = 512
DW, 8, sample width

Ports:
rclk  input  1  clock, same clock as RAM; all logic rising-edge
rst  input  1  synchronous active-high reset
arm  input  1  pulse: start or restart a capture
smpl_vld  input  1  incoming sample strobe
smpl  input  DW  incoming sample
trig_lvl  input  DW  trigger threshold, unsigned
trig_edge  input  1  1 = rising edge, 0 = falling edge
trig_pos  input  AW  number of post-trigger samples; latched at arm
decim  input  4  keep 1 of every decim+1 valid samples; latched at arm
rd_req  input  1  pulse: start readout; honoured only in DONE
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_wdata  output  DW  RAM write data
ram_rdata  input  DW  RAM read data, valid 1 cycle after the read-enable cycle
rd_data  output  DW  readout sample
rd_vld  output  1  rd_data valid strobe
triggered  output  1  trigger has occurred in the current capture
capture_done  output  1  buffer holds a complete capture
busy  output  1  state is PRE_FILL, WAIT_TRIG, POST or READ

Behaviour:
- Reset: state=IDLE; all outputs 0; wr_ptr, counters and prev-sample-valid cleared; no RAM access in the reset cycle. Reset mid-capture or mid-readout aborts immediately.
- States:
  - IDLE: wait for arm.
  - PRE_FILL: write samples; trigger disabled.
  - WAIT_TRIG: write samples; trigger enabled.
  - POST: write samples.
  - DONE: capture_done=1.
  - READ: stream the buffer out.
- arm (any state except during rst): latch trig_pos and decim; clear wr_ptr, decim_cnt, pre_cnt, post_cnt, triggered, capture_done and prev-valid; go to PRE_FILL. If arm and rd_req arrive in the same cycle, arm wins.
- Accept rule: a sample is accepted when smpl_vld=1 and decim_cnt==decim. On acceptance decim_cnt<=0; on any other smpl_vld, decim_cnt increments. With decim=0 every valid sample is accepted.
- Write: in PRE_FILL, WAIT_TRIG and POST, an accepted sample drives ram_en=1, ram_we=1, ram_addr=wr_ptr and ram_wdata=smpl combinationally in the same cycle. wr_ptr then increments, wrapping 511 to 0. In all other cycles ram_we=0.
- trig_pos of 0 is treated as 1. pre_len = 512 - trig_pos.
- PRE_FILL to WAIT_TRIG: on the accepted sample that makes pre_cnt reach pre_len.
- Trigger condition (WAIT_TRIG only, on accepted sample cur, with prev = previous accepted sample and prev-valid=1):
  - rising: prev < trig_lvl and cur >= trig_lvl.
  - falling: prev > trig_lvl and cur <= trig_lvl.
  - prev is updated on every accepted sample in every capture state.
- On trigger: triggered<=1; the trigger sample is written and counts as post sample 1; go to POST, or go straight to DONE if trig_pos=1.
- POST to DONE: on the accepted sample making post_cnt==trig_pos. At that point wr_ptr points at the oldest sample; latch it as rd_base.
- DONE: on rd_req, go to READ with rd_cnt=0.
- READ: each cycle drive ram_en=1, ram_we=0, ram_addr=rd_base+rd_cnt (mod 512), then rd_cnt++.
  - rd_vld=1 and rd_data=ram_rdata one cycle after each read cycle.
  - Exactly 512 reads, then go to IDLE with capture_done<=0; the last rd_vld occurs in the first IDLE cycle.
  - smpl_vld is ignored during READ.
- arm during READ aborts the readout. No rd_vld is produced for reads issued in the arm cycle or after it.

Test Plan:
1. rst held for 2 cycles with smpl_vld=1 -> all outputs 0, ram_we never 1, state IDLE.
2. decim=0, trig_pos=256, trig_edge=1, trig_lvl=0x80, ramp 0x00..0xFF repeating -> trigger on the 0x7F to 0x80 step only after 256 pre-samples. Capture_done is asserted after the 256th post sample, counting the trigger sample. Readout gives 512 rd_vld pulses, and the sample at readout index 256 equals 0x80.
3. decim=3, constant smpl_vld -> ram_we asserted every 4th cycle; wr_ptr wraps 511 to 0 with no gap.
4. Falling edge, lvl=0x40, input 0x50,0x40 arriving during PRE_FILL, then 0x50,0x30 during WAIT_TRIG -> no trigger during PRE_FILL; trigger on 0x30.
5. trig_pos=0 -> behaves as trig_pos=1: DONE on the trigger sample itself; rd_base = trigger address + 1.
6. arm asserted mid-READ and in the same cycle as rd_req in DONE -> readout aborts, capture restarts in PRE_FILL, capture_done=0, rd_vld ceases.
